gray_counter_bank: RTL and testbench

//  Bank of NCHAN independent WIDTH-bit up/down counters, each kept in binary and mirrored as Gray code.

---
 rtl/gray_counter_bank.sv | 171 +++++++++++++++++
 tb/tb_gray_counter_bank.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_bank.sv
// Bank of independent up/down counters kept in binary and mirrored as registered Gray code,
// driven by a single command channel with a one-entry buffered read-response channel.
module gray_counter_bank #(
    parameter int WIDTH    = 4,
    parameter int NCHAN    = 4,
    parameter int SATURATE = 0,
    localparam int CW      = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   cmd__ENA,
    output logic                   cmd__RDY,
    input  logic [2:0]             cmd_op,
    input  logic [CW-1:0]          cmd_chan,
    input  logic [WIDTH-1:0]       cmd_v,
    output logic                   rsp__ENA,
    input  logic                   rsp__RDY,
    output logic [WIDTH-1:0]       rsp_v,
    output logic [CW-1:0]          rsp_chan,
    output logic                   rsp_err,
    output logic [NCHAN*WIDTH-1:0] gray_out,
    output logic [NCHAN-1:0]       wrap_flag
);

    typedef enum logic [2:0] {
        OP_INC      = 3'd0,
        OP_DEC      = 3'd1,
        OP_RD_GRAY  = 3'd2,
        OP_WR_GRAY  = 3'd3,
        OP_RD_BIN   = 3'd4,
        OP_WR_BIN   = 3'd5,
        OP_CLR_FLAG = 3'd6,
        OP_RSVD     = 3'd7
    } op_e;

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    op_e              op;
    logic             accept;
    logic             is_read;
    logic             rd_hit;
    logic [WIDTH-1:0] rd_bin;
    logic [WIDTH-1:0] bin_vec [NCHAN];

    logic             rsp_ena_reg;
    logic [WIDTH-1:0] rsp_v_reg;
    logic [CW-1:0]    rsp_chan_reg;
    logic             rsp_err_reg;

    assign op       = op_e'(cmd_op);
    assign cmd__RDY = !RST && (!rsp_ena_reg || rsp__RDY);
    assign accept   = cmd__ENA && cmd__RDY;
    assign is_read  = (op == OP_RD_GRAY) || (op == OP_RD_BIN);

    assign rsp__ENA = rsp_ena_reg;
    assign rsp_v    = rsp_v_reg;
    assign rsp_chan = rsp_chan_reg;
    assign rsp_err  = rsp_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NCHAN; gi++) begin : g_chan
            logic             hit;
            logic [WIDTH-1:0] bin_reg;
            logic [WIDTH-1:0] bin_next;
            logic [WIDTH-1:0] gray_reg;
            logic             flag_reg;
            logic             flag_set;
            logic             flag_clr;

            assign hit = accept && (cmd_chan == CW'(gi));

            always_comb begin
                bin_next = bin_reg;
                flag_set = 1'b0;
                flag_clr = 1'b0;
                if (hit) begin
                    case (op)
                        OP_INC: begin
                            if (bin_reg == MAX_VAL) begin
                                flag_set = 1'b1;
                                bin_next = (SATURATE != 0) ? MAX_VAL : '0;
                            end else begin
                                bin_next = bin_reg + ONE;
                            end
                        end
                        OP_DEC: begin
                            if (bin_reg == '0) begin
                                flag_set = 1'b1;
                                bin_next = (SATURATE != 0) ? '0 : MAX_VAL;
                            end else begin
                                bin_next = bin_reg - ONE;
                            end
                        end
                        OP_WR_GRAY:  bin_next = gray2bin(cmd_v);
                        OP_WR_BIN:   bin_next = cmd_v;
                        OP_CLR_FLAG: flag_clr = 1'b1;
                        default:     bin_next = bin_reg;
                    endcase
                end
            end

            // Gray mirror is registered from the next binary value so it tracks bin_reg exactly.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    bin_reg  <= '0;
                    gray_reg <= '0;
                    flag_reg <= 1'b0;
                end else begin
                    bin_reg  <= bin_next;
                    gray_reg <= bin2gray(bin_next);
                    flag_reg <= (flag_reg && !flag_clr) || flag_set;
                end
            end

            assign bin_vec[gi]                   = bin_reg;
            assign gray_out[gi*WIDTH +: WIDTH]   = gray_reg;
            assign wrap_flag[gi]                 = flag_reg;
        end
    endgenerate

    // Channel read mux; an index with no matching counter leaves rd_hit low.
    always_comb begin
        rd_bin = '0;
        rd_hit = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (cmd_chan == CW'(i)) begin
                rd_bin = bin_vec[i];
                rd_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_ena_reg  <= 1'b0;
            rsp_v_reg    <= '0;
            rsp_chan_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else if (accept && is_read) begin
            rsp_ena_reg  <= 1'b1;
            rsp_chan_reg <= cmd_chan;
            rsp_err_reg  <= !rd_hit;
            if (!rd_hit) begin
                rsp_v_reg <= '0;
            end else if (op == OP_RD_GRAY) begin
                rsp_v_reg <= bin2gray(rd_bin);
            end else begin
                rsp_v_reg <= rd_bin;
            end
        end else if (rsp__RDY) begin
            rsp_ena_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_counter_bank.sv
// Self-checking bench: three bank variants (wrap, saturate, three channels) share one command stream.
module tb_gray_counter_bank;

    localparam logic [2:0] OP_INC = 3'd0, OP_DEC = 3'd1, OP_RD_GRAY = 3'd2, OP_WR_GRAY = 3'd3;
    localparam logic [2:0] OP_RD_BIN = 3'd4, OP_WR_BIN = 3'd5, OP_CLR = 3'd6, OP_RSVD = 3'd7;

    logic       CLK = 1'b0;
    logic       RST;
    logic       cmd_ena;
    logic       rsp_rdy;
    logic [2:0] cmd_op;
    logic [1:0] cmd_chan;
    logic [3:0] cmd_v;

    logic        rdy0, ena0, err0, rdy1, ena1, err1, rdy2, ena2, err2;
    logic [3:0]  v0, v1, v2;
    logic [1:0]  ch0, ch1, ch2;
    logic [15:0] g0, g1;
    logic [11:0] g2;
    logic [3:0]  f0, f1;
    logic [2:0]  f2;

    always #5 CLK = ~CLK;

    gray_counter_bank #(.WIDTH(4), .NCHAN(4), .SATURATE(0)) dut (
        .CLK(CLK), .RST(RST), .cmd__ENA(cmd_ena), .cmd__RDY(rdy0), .cmd_op(cmd_op),
        .cmd_chan(cmd_chan), .cmd_v(cmd_v), .rsp__ENA(ena0), .rsp__RDY(rsp_rdy), .rsp_v(v0),
        .rsp_chan(ch0), .rsp_err(err0), .gray_out(g0), .wrap_flag(f0));

    gray_counter_bank #(.WIDTH(4), .NCHAN(4), .SATURATE(1)) dut_sat (
        .CLK(CLK), .RST(RST), .cmd__ENA(cmd_ena), .cmd__RDY(rdy1), .cmd_op(cmd_op),
        .cmd_chan(cmd_chan), .cmd_v(cmd_v), .rsp__ENA(ena1), .rsp__RDY(rsp_rdy), .rsp_v(v1),
        .rsp_chan(ch1), .rsp_err(err1), .gray_out(g1), .wrap_flag(f1));

    gray_counter_bank #(.WIDTH(4), .NCHAN(3), .SATURATE(0)) dut3 (
        .CLK(CLK), .RST(RST), .cmd__ENA(cmd_ena), .cmd__RDY(rdy2), .cmd_op(cmd_op),
        .cmd_chan(cmd_chan), .cmd_v(cmd_v), .rsp__ENA(ena2), .rsp__RDY(rsp_rdy), .rsp_v(v2),
        .rsp_chan(ch2), .rsp_err(err2), .gray_out(g2), .wrap_flag(f2));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain integer counters per bank variant.
    int  nch [3];
    bit  sat [3];
    int  cnt [3][4];
    bit  flg [3][4];
    bit  mv  [3];
    int  mrv [3];
    int  mch [3];
    bit  merr[3];
    bit  rdy_seen;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int ungray(input int g);
        for (int b = 0; b < 16; b++) begin
            if (gray(b) == g) return b;
        end
        return 0;
    endfunction

    function automatic void chk(input string name, input int m, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got %0h, expected %0h", name, m, act, exp);
        end
    endfunction

    task automatic model_step(input bit rst, input bit ena, input logic [2:0] op,
                              input int ch, input int v, input bit rrdy);
        bit rdy;
        bit inr;
        int n;
        for (int m = 0; m < 3; m++) begin
            rdy = !rst && (!mv[m] || rrdy);
            if (rst) begin
                for (int c = 0; c < 4; c++) begin
                    cnt[m][c] = 0;
                    flg[m][c] = 1'b0;
                end
                mv[m] = 1'b0; mrv[m] = 0; mch[m] = 0; merr[m] = 1'b0;
            end else begin
                if (mv[m] && rrdy) mv[m] = 1'b0;
                if (ena && rdy) begin
                    inr = ch < nch[m];
                    case (op)
                        OP_INC: if (inr) begin
                            n = cnt[m][ch] + 1;
                            if (n > 15) begin flg[m][ch] = 1'b1; n = sat[m] ? 15 : 0; end
                            cnt[m][ch] = n;
                        end
                        OP_DEC: if (inr) begin
                            n = cnt[m][ch] - 1;
                            if (n < 0) begin flg[m][ch] = 1'b1; n = sat[m] ? 0 : 15; end
                            cnt[m][ch] = n;
                        end
                        OP_RD_GRAY, OP_RD_BIN: begin
                            mv[m]   = 1'b1;
                            mch[m]  = ch;
                            merr[m] = !inr;
                            mrv[m]  = !inr ? 0 : (op == OP_RD_GRAY ? gray(cnt[m][ch]) : cnt[m][ch]);
                        end
                        OP_WR_GRAY: if (inr) cnt[m][ch] = ungray(v);
                        OP_WR_BIN:  if (inr) cnt[m][ch] = v;
                        OP_CLR:     if (inr) flg[m][ch] = 1'b0;
                        default: ;
                    endcase
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [15:0] exp_g;
        logic [3:0]  exp_f;
        for (int m = 0; m < 3; m++) begin
            exp_g = '0;
            exp_f = '0;
            for (int c = 0; c < nch[m]; c++) begin
                exp_g[c*4 +: 4] = 4'(gray(cnt[m][c]));
                exp_f[c]        = flg[m][c];
            end
            case (m)
                0: begin
                    chk("rsp_ena", m, int'(ena0), int'(mv[m]));
                    chk("rsp_v", m, int'(v0), mrv[m]);
                    chk("rsp_chan", m, int'(ch0), mch[m]);
                    chk("rsp_err", m, int'(err0), int'(merr[m]));
                    chk("gray_out", m, int'(g0), int'(exp_g));
                    chk("wrap_flag", m, int'(f0), int'(exp_f));
                end
                1: begin
                    chk("rsp_ena", m, int'(ena1), int'(mv[m]));
                    chk("rsp_v", m, int'(v1), mrv[m]);
                    chk("rsp_chan", m, int'(ch1), mch[m]);
                    chk("rsp_err", m, int'(err1), int'(merr[m]));
                    chk("gray_out", m, int'(g1), int'(exp_g));
                    chk("wrap_flag", m, int'(f1), int'(exp_f));
                end
                default: begin
                    chk("rsp_ena", m, int'(ena2), int'(mv[m]));
                    chk("rsp_v", m, int'(v2), mrv[m]);
                    chk("rsp_chan", m, int'(ch2), mch[m]);
                    chk("rsp_err", m, int'(err2), int'(merr[m]));
                    chk("gray_out", m, int'(g2), int'(exp_g));
                    chk("wrap_flag", m, int'(f2), int'(exp_f));
                end
            endcase
        end
    endtask

    // One clock: drive, check ready against the model, advance model, sample 1ns after the edge.
    task automatic cycle(input bit rst, input bit ena, input logic [2:0] op,
                         input logic [1:0] ch, input logic [3:0] v, input bit rrdy);
        bit mrdy;
        RST = rst; cmd_ena = ena; cmd_op = op; cmd_chan = ch; cmd_v = v; rsp_rdy = rrdy;
        #1;
        mrdy     = !rst && (!mv[0] || rrdy);
        rdy_seen = rdy0;
        chk("cmd_rdy", 0, int'(rdy0), int'(mrdy));
        chk("cmd_rdy", 1, int'(rdy1), int'(mrdy));
        chk("cmd_rdy", 2, int'(rdy2), int'(mrdy));
        model_step(rst, ena, op, int'(ch), int'(v), rrdy);
        @(posedge CLK);
        #1;
        compare_all();
        $display("[TB] t=%0t rst=%0d ena=%0d op=%0d ch=%0d v=%0h rrdy=%0d -> rsp_ena=%0d rsp_v=%0h gray=%04h flags=%04b",
                 $time, rst, ena, op, ch, v, rrdy, ena0, v0, g0, f0);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [1:0] ch;
        logic [3:0] v;
        bit         exp_ena;
        logic [3:0] exp_v;
        logic [3:0] exp_g;
        bit         exp_f;
    } vec_t;

    vec_t tbl[14];
    logic [3:0] prev_g;

    initial begin
        nch[0] = 4; nch[1] = 4; nch[2] = 3;
        sat[0] = 1'b0; sat[1] = 1'b1; sat[2] = 1'b0;
        for (int m = 0; m < 3; m++) begin
            mv[m] = 1'b0; mrv[m] = 0; mch[m] = 0; merr[m] = 1'b0;
            for (int c = 0; c < 4; c++) begin cnt[m][c] = 0; flg[m][c] = 1'b0; end
        end

        tbl[0]  = '{OP_INC,     2'd2, 4'h0, 1'b0, 4'h0, 4'h1, 1'b0};
        tbl[1]  = '{OP_INC,     2'd2, 4'h0, 1'b0, 4'h0, 4'h3, 1'b0};
        tbl[2]  = '{OP_INC,     2'd2, 4'h0, 1'b0, 4'h0, 4'h2, 1'b0};
        tbl[3]  = '{OP_RD_BIN,  2'd2, 4'h0, 1'b1, 4'h3, 4'h2, 1'b0};
        tbl[4]  = '{OP_RD_GRAY, 2'd2, 4'h0, 1'b1, 4'h2, 4'h2, 1'b0};
        tbl[5]  = '{OP_WR_BIN,  2'd0, 4'hF, 1'b0, 4'h0, 4'h8, 1'b0};
        tbl[6]  = '{OP_INC,     2'd0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1};
        tbl[7]  = '{OP_CLR,     2'd0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0};
        tbl[8]  = '{OP_WR_GRAY, 2'd3, 4'h8, 1'b0, 4'h0, 4'h8, 1'b0};
        tbl[9]  = '{OP_RD_BIN,  2'd3, 4'h0, 1'b1, 4'hF, 4'h8, 1'b0};
        tbl[10] = '{OP_DEC,     2'd1, 4'h0, 1'b0, 4'h0, 4'h8, 1'b1};
        tbl[11] = '{OP_RSVD,    2'd1, 4'h3, 1'b0, 4'h0, 4'h8, 1'b1};
        tbl[12] = '{OP_WR_BIN,  2'd1, 4'h5, 1'b0, 4'h0, 4'h7, 1'b1};
        tbl[13] = '{OP_RD_GRAY, 2'd1, 4'h0, 1'b1, 4'h7, 4'h7, 1'b1};

        // Reset state
        cycle(1'b1, 1'b0, OP_INC, 2'd0, 4'h0, 1'b1);
        cycle(1'b1, 1'b0, OP_INC, 2'd0, 4'h0, 1'b1);
        chk("reset_rdy", 0, int'(rdy_seen), 0);
        chk("reset_gray", 0, int'(g0), 0);
        chk("reset_flag", 0, int'(f0), 0);
        chk("reset_rsp_ena", 0, int'(ena0), 0);

        // Directed vectors on the wrapping bank
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 1'b1, tbl[i].op, tbl[i].ch, tbl[i].v, 1'b1);
            chk("vec_rsp_ena", i, int'(ena0), int'(tbl[i].exp_ena));
            if (tbl[i].exp_ena) begin
                chk("vec_rsp_v", i, int'(v0), int'(tbl[i].exp_v));
                chk("vec_rsp_chan", i, int'(ch0), int'(tbl[i].ch));
            end
            chk("vec_gray", i, int'(g0[int'(tbl[i].ch)*4 +: 4]), int'(tbl[i].exp_g));
            chk("vec_flag", i, int'(f0[tbl[i].ch]), int'(tbl[i].exp_f));
        end

        // Saturating bank clamps and flags the blocked step
        cycle(1'b0, 1'b1, OP_WR_BIN, 2'd1, 4'h0, 1'b1);
        cycle(1'b0, 1'b1, OP_CLR,    2'd1, 4'h0, 1'b1);
        cycle(1'b0, 1'b1, OP_DEC,    2'd1, 4'h0, 1'b1);
        chk("sat_dec_hold", 1, int'(g1[7:4]), 0);
        chk("sat_dec_flag", 1, int'(f1[1]), 1);
        cycle(1'b0, 1'b1, OP_CLR,    2'd1, 4'h0, 1'b1);
        cycle(1'b0, 1'b1, OP_WR_BIN, 2'd1, 4'hF, 1'b1);
        cycle(1'b0, 1'b1, OP_INC,    2'd1, 4'h0, 1'b1);
        chk("sat_inc_hold", 1, int'(g1[7:4]), 8);
        chk("sat_inc_flag", 1, int'(f1[1]), 1);

        // One Gray bit changes per increment over 32 steps
        cycle(1'b0, 1'b1, OP_WR_GRAY, 2'd3, 4'h8, 1'b1);
        for (int i = 0; i < 32; i++) begin
            prev_g = g0[15:12];
            cycle(1'b0, 1'b1, OP_INC, 2'd3, 4'h0, 1'b1);
            chk("gray_one_bit", i, $countones(prev_g ^ g0[15:12]), 1);
        end

        // Backpressure: pending response stalls the next command
        cycle(1'b1, 1'b0, OP_INC, 2'd0, 4'h0, 1'b0);
        cycle(1'b0, 1'b1, OP_RD_BIN, 2'd2, 4'h0, 1'b0);
        chk("bp_rsp_ena", 0, int'(ena0), 1);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, OP_INC, 2'd2, 4'h0, 1'b0);
            chk("bp_stall_rdy", i, int'(rdy_seen), 0);
            chk("bp_not_applied", i, int'(g0[11:8]), 0);
        end
        cycle(1'b0, 1'b1, OP_INC, 2'd2, 4'h0, 1'b1);
        chk("bp_drain_rdy", 0, int'(rdy_seen), 1);
        chk("bp_applied", 0, int'(g0[11:8]), 1);
        chk("bp_rsp_done", 0, int'(ena0), 0);

        // Reset in the middle of a stall
        cycle(1'b0, 1'b1, OP_RD_GRAY, 2'd2, 4'h0, 1'b0);
        cycle(1'b1, 1'b1, OP_INC, 2'd2, 4'h0, 1'b0);
        chk("rst_stall_rdy", 0, int'(rdy_seen), 0);
        chk("rst_stall_ena", 0, int'(ena0), 0);
        chk("rst_stall_gray", 0, int'(g0), 0);

        // Out-of-range channel on the three-channel bank
        cycle(1'b0, 1'b1, OP_RD_BIN, 2'd3, 4'h0, 1'b1);
        chk("oor_rsp_ena", 2, int'(ena2), 1);
        chk("oor_rsp_err", 2, int'(err2), 1);
        chk("oor_rsp_v", 2, int'(v2), 0);
        cycle(1'b0, 1'b1, OP_INC, 2'd3, 4'h0, 1'b1);
        chk("oor_inc_gray", 2, int'(g2), 0);
        chk("oor_inc_flag", 2, int'(f2), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 63) == 0, ($urandom % 4) != 0, 3'($urandom % 8),
                  2'($urandom % 4), 4'($urandom % 16), ($urandom % 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
